// File: rtl/coarse_switch_sequencer_pkg.sv
// Shared CDU coarse-system definitions: FSM states, switch bit positions and quadrant sign table.
package coarse_switch_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_BBM    = 3'd1,
        ST_SECT   = 3'd2,
        ST_SUM    = 3'd3,
        ST_BIAS   = 3'd4,
        ST_SAMPLE = 3'd5,
        ST_REL    = 3'd6,
        ST_DONE   = 3'd7
    } state_t;

    localparam int SW_W  = 14;
    localparam int SW_D1 = 0;
    localparam int SW_D2 = 1;
    localparam int SW_D3 = 2;
    localparam int SW_D4 = 3;
    localparam int SW_D5 = 4;
    localparam int SW_D6 = 5;
    localparam int SW_D7 = 6;
    localparam int SW_D8 = 7;
    localparam int SW_D9 = 8;
    localparam int SW_D10 = 9;
    localparam int SW_D11 = 10;
    localparam int SW_D12 = 11;
    localparam int SW_D13 = 12;
    localparam int SW_D14 = 13;

    localparam logic [SW_W-1:0] SW_ALL_OPEN = 14'h3FFF;

    // {D5, D7} sign drive per quadrant, packed as {q3, q2, q1, q0}
    localparam logic [7:0] QUAD_SIGN_TABLE = {2'b10, 2'b11, 2'b01, 2'b00};

    function automatic logic [SW_W-1:0] sw_bit(input int idx);
        logic [SW_W-1:0] m;
        m = '0;
        m[idx] = 1'b1;
        return m;
    endfunction

    function automatic logic [SW_W-1:0] bbm_drive(input logic [1:0] quad);
        logic [1:0]      sign;
        logic [SW_W-1:0] d;
        sign = QUAD_SIGN_TABLE[{quad, 1'b0} +: 2];
        d = SW_ALL_OPEN;
        d[SW_D5] = sign[1];
        d[SW_D7] = sign[0];
        return d;
    endfunction

endpackage

// File: rtl/coarse_switch_sequencer_if.sv
// Request/result and switch-drive bundle between the read-counter logic and the coarse sequencer.
interface coarse_switch_sequencer_if;
    logic        start_i;
    logic [3:0]  angle_i;
    logic        cmp_a_i;
    logic        cmp_b_i;
    logic        ready_o;
    logic        done_o;
    logic        err_a_o;
    logic        err_b_o;
    logic [13:0] d_n_o;

    modport master (
        output start_i, angle_i, cmp_a_i, cmp_b_i,
        input  ready_o, done_o, err_a_o, err_b_o, d_n_o
    );

    modport slave (
        input  start_i, angle_i, cmp_a_i, cmp_b_i,
        output ready_o, done_o, err_a_o, err_b_o, d_n_o
    );
endinterface

// File: rtl/coarse_switch_sequencer_settle_timer.sv
// Reusable phase-settle down-counter: load S-1 on phase entry, expired at zero, never wraps.
module settle_timer #(
    parameter int SETTLE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic count_en,
    output logic expired
);
    localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(SETTLE_CYCLES - 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= LOAD_VAL;
        end else if (count_en && (count != '0)) begin
            count <= count - CNT_W'(1);
        end
    end

    assign expired = (count == '0);
endmodule

// File: rtl/coarse_switch_sequencer.sv
// Break-before-make sequencer for the coarse analog switches D1..D14 with comparator sampling.
module coarse_switch_sequencer
    import coarse_switch_sequencer_pkg::*;
#(
    parameter int SETTLE_CYCLES = 16
) (
    input logic                     clk,
    input logic                     rst,
    coarse_switch_sequencer_if.slave bus
);
    state_t          state;
    logic [3:0]      angle_q;
    logic [1:0]      sync_p0;
    logic [1:0]      sync_p1;
    logic [SW_W-1:0] d_n;
    logic            ready;
    logic            done;
    logic            err_a;
    logic            err_b;
    logic            timer_load;
    logic            timer_en;
    logic            expired;
    logic [1:0]      quad;
    logic [1:0]      sect;
    logic [SW_W-1:0] sect_mask;
    logic [SW_W-1:0] fb_mask;

    assign quad      = angle_q[3:2];
    assign sect      = angle_q[1:0];
    assign sect_mask = sw_bit(SW_D1 + int'(sect));
    assign fb_mask   = sect[1] ? sw_bit(SW_D14) : sw_bit(SW_D11);

    // Timer is reloaded entering SECT (from BBM) and on each expiry hand-off to the next settle phase
    assign timer_load = (state == ST_BBM) ||
                        (((state == ST_SECT) || (state == ST_SUM)) && expired);
    assign timer_en   = (state == ST_SECT) || (state == ST_SUM) || (state == ST_BIAS);

    settle_timer #(.SETTLE_CYCLES(SETTLE_CYCLES)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (timer_load),
        .count_en (timer_en),
        .expired  (expired)
    );

    // Comparator synchroniser: p0 captures the async inputs, p1 is the stable copy
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_p0 <= '0;
            sync_p1 <= '0;
        end else begin
            sync_p0 <= {bus.cmp_b_i, bus.cmp_a_i};
            sync_p1 <= sync_p0;
        end
    end

    always_ff @(posedge clk) begin
        if ((state == ST_IDLE) && bus.start_i) begin
            angle_q <= bus.angle_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            d_n   <= SW_ALL_OPEN;
            ready <= 1'b1;
            done  <= 1'b0;
            err_a <= 1'b0;
            err_b <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (bus.start_i) begin
                        state <= ST_BBM;
                        ready <= 1'b0;
                        d_n   <= bbm_drive(bus.angle_i[3:2]);
                    end
                end
                ST_BBM: begin
                    state <= ST_SECT;
                    d_n   <= bbm_drive(quad) & ~sect_mask;
                end
                ST_SECT: begin
                    if (expired) begin
                        state <= ST_SUM;
                        d_n   <= d_n & ~(sw_bit(SW_D9) | sw_bit(SW_D12) | fb_mask);
                    end
                end
                ST_SUM: begin
                    if (expired) begin
                        state <= ST_BIAS;
                        d_n   <= d_n & ~(sw_bit(SW_D10) | sw_bit(SW_D13));
                    end
                end
                ST_BIAS: begin
                    if (expired) begin
                        state <= ST_SAMPLE;
                    end
                end
                ST_SAMPLE: begin
                    state <= ST_REL;
                    err_a <= sync_p1[0];
                    err_b <= sync_p1[1];
                    d_n   <= bbm_drive(quad) & ~sect_mask;
                end
                ST_REL: begin
                    state <= ST_DONE;
                    d_n   <= SW_ALL_OPEN;
                    done  <= 1'b1;
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    done  <= 1'b0;
                    ready <= 1'b1;
                end
                default: begin
                    state <= ST_IDLE;
                    d_n   <= SW_ALL_OPEN;
                    ready <= 1'b1;
                    done  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.d_n_o   = d_n;
    assign bus.ready_o = ready;
    assign bus.done_o  = done;
    assign bus.err_a_o = err_a;
    assign bus.err_b_o = err_b;
endmodule
